// File: rtl/image_pkg.sv
// -----------------------------------------------------------------------------
// image_pkg
// Shared types and constants for the image frame capture path.
//   pixel_t         24-bit RGB pixel (8b R, 8b G, 8b B)
//   addr_t          17-bit frame address
//   IMAGE_PIXELS    pixels per 300x300 frame
//   writer_state_t  capture FSM states {IDLE, WRITE, DONE}
//   addr_in_frame   true when an address lies inside a frame of a given size
// -----------------------------------------------------------------------------
package image_pkg;

   localparam int unsigned IMAGE_DATA_WIDTH = 32'd24;
   localparam int unsigned IMAGE_ADDR_WIDTH = 32'd17;
   localparam int unsigned IMAGE_PIXELS     = 32'd90000;

   typedef logic [IMAGE_DATA_WIDTH-1:0] pixel_t;
   typedef logic [IMAGE_ADDR_WIDTH-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      DONE  = 2'b10
   } writer_state_t;

   // Addresses at or beyond the frame size never touch the RAM array.
   function automatic logic addr_in_frame(input int unsigned addr,
                                          input int unsigned pixels);
      return (addr < pixels);
   endfunction

endpackage

// File: rtl/image_frame_ram.sv
// -----------------------------------------------------------------------------
// image_frame_ram
// Simple dual-port frame RAM: one write port, one registered read port.
// A read and a write to the same address in the same cycle return the old
// contents. The read register returns zero when the read is disabled or the
// address lies outside the frame. Array contents are not cleared by reset.
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset (read register only)
//   write_enable   store write_data at write_address this cycle
//   write_address  write address
//   write_data     write data
//   read_enable    read port enable
//   read_address   read address
//   read_data      registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module image_frame_ram
   import image_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = IMAGE_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = IMAGE_ADDR_WIDTH,
   parameter int unsigned DEPTH      = IMAGE_PIXELS
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] read_data
);

   logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
   logic                  write_hit_s;
   logic                  read_hit_s;
   logic [DATA_WIDTH-1:0] read_data_r;

   assign write_hit_s = write_enable & addr_in_frame(32'(write_address), DEPTH);
   assign read_hit_s  = read_enable  & addr_in_frame(32'(read_address),  DEPTH);

   // Frame storage write port; no reset so the array maps onto block RAM.
   always_ff @(posedge clock) begin
      if (write_hit_s) begin
         mem_r[write_address] <= write_data;
      end
   end

   // Registered read port; samples the array before this edge's write lands.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_data_r <= {DATA_WIDTH{1'b0}};
      end else if (read_hit_s) begin
         read_data_r <= mem_r[read_address];
      end else begin
         read_data_r <= {DATA_WIDTH{1'b0}};
      end
   end

   assign read_data = read_data_r;

endmodule

// File: rtl/image_ram_writer.sv
// -----------------------------------------------------------------------------
// image_ram_writer
// Captures one raster-ordered frame of RGB pixels from a valid/ready stream
// into the internal frame RAM at addresses 0..PIXELS-1, and exposes the stored
// frame through a registered read port.
// Optional feature macro: CHECKSUM_EN adds a running modulo-2**DATA_WIDTH sum
// of all accepted pixels of the current frame on output checksum.
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          arm capture of one frame (honoured in IDLE or DONE)
//   pixel_valid    pixel_data is valid
//   pixel_data     pixel to store
//   pixel_ready    a pixel can be accepted this cycle (state is WRITE)
//   busy           capture in progress
//   done           full frame stored; held until the next start
//   write_count    pixels stored in the current/last frame
//   read_enable    read port enable
//   read_address   read address
//   read_data      registered read data (1-cycle latency, zero when disabled
//                  or out of frame)
//   checksum       (CHECKSUM_EN only) sum of accepted pixels this frame
// -----------------------------------------------------------------------------
module image_ram_writer
   import image_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = IMAGE_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = IMAGE_ADDR_WIDTH,
   parameter int unsigned PIXELS     = IMAGE_PIXELS
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  pixel_valid,
   input  logic [DATA_WIDTH-1:0] pixel_data,
   output logic                  pixel_ready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] write_count,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] read_data
`ifdef CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   localparam logic [ADDR_WIDTH-1:0] COUNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(PIXELS - 32'd1);

   writer_state_t         state_r;
   writer_state_t         next_state_s;
   logic                  arm_s;
   logic                  accept_s;
   logic                  last_s;
   logic                  in_write_s;
   logic [ADDR_WIDTH-1:0] write_count_r;

   assign in_write_s = (state_r == WRITE);
   assign accept_s   = pixel_valid & in_write_s;
   // The pixel being accepted is the final one of the frame.
   assign last_s     = (write_count_r == LAST_INDEX);

   // Capture FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Capture FSM next state; arm_s marks the edge that enters WRITE.
   always_comb begin
      next_state_s = state_r;
      arm_s        = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               next_state_s = WRITE;
               arm_s        = 1'b1;
            end else begin
               next_state_s = state_r;
            end
         end
         WRITE: begin
            // start is deliberately not looked at here: a frame runs to completion.
            if (accept_s && last_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = WRITE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Pixel counter doubling as the RAM write address; stops at PIXELS.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_count_r <= {ADDR_WIDTH{1'b0}};
      end else if (arm_s) begin
         write_count_r <= {ADDR_WIDTH{1'b0}};
      end else if (accept_s) begin
         write_count_r <= write_count_r + COUNT_ONE;
      end else begin
         write_count_r <= write_count_r;
      end
   end

`ifdef CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum_r;

   // Running frame checksum; wraps naturally at the register width.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         checksum_r <= {DATA_WIDTH{1'b0}};
      end else if (arm_s) begin
         checksum_r <= {DATA_WIDTH{1'b0}};
      end else if (accept_s) begin
         checksum_r <= checksum_r + pixel_data;
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign checksum = checksum_r;
`endif

   assign pixel_ready = in_write_s;
   assign busy        = in_write_s;
   assign done        = (state_r == DONE);
   assign write_count = write_count_r;

   image_frame_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (PIXELS)
   ) u_frame_ram (
      .clock         (clock),
      .reset_n       (reset_n),
      .write_enable  (accept_s),
      .write_address (write_count_r),
      .write_data    (pixel_data),
      .read_enable   (read_enable),
      .read_address  (read_address),
      .read_data     (read_data)
   );

endmodule

// File: tb/tb_image_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_image_ram_writer
// Randomized self-checking bench for image_ram_writer. A frame-level reference
// (capturing/done flags, pixel count, array of stored pixels with a "written"
// mask, running sum) predicts every output each cycle.
// Build with +define+CHECKSUM_EN to exercise the checksum output as well.
// -----------------------------------------------------------------------------
module tb_image_ram_writer;

   localparam int PIXELS = 90000;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        pixel_valid;
   logic [23:0] pixel_data;
   logic        pixel_ready;
   logic        busy;
   logic        done;
   logic [16:0] write_count;
   logic        read_enable;
   logic [16:0] read_address;
   logic [23:0] read_data;
`ifdef CHECKSUM_EN
   logic [23:0] checksum;
`endif

   image_ram_writer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .pixel_valid  (pixel_valid),
      .pixel_data   (pixel_data),
      .pixel_ready  (pixel_ready),
      .busy         (busy),
      .done         (done),
      .write_count  (write_count),
      .read_enable  (read_enable),
      .read_address (read_address),
      .read_data    (read_data)
`ifdef CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // reference model of the frame
   logic [23:0] mem_m   [0:PIXELS-1];
   bit          known_m [0:PIXELS-1];
   bit          cap_m;
   bit          done_m;
   int          cnt_m;
   logic [23:0] sum_m;
   int          frames_m;

   int          n_total;
   int          n_bad;
   int          done_rises;
   bit          prev_done;
   logic [23:0] saved_1500;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: predict from current inputs, advance, compare.
   task automatic tick();
      logic [23:0] rd_exp;
      bit          rd_chk;
      check_eq("pixel_ready", {31'd0, pixel_ready}, {31'd0, cap_m});
      rd_chk = 1'b1;
      rd_exp = 24'h000000;
      if (read_enable && read_address < PIXELS) begin
         rd_chk = known_m[read_address];
         rd_exp = mem_m[read_address];
      end
      if (!cap_m) begin
         if (start) begin
            cap_m  = 1'b1;
            done_m = 1'b0;
            cnt_m  = 0;
            sum_m  = 24'h000000;
         end
      end else if (pixel_valid) begin
         mem_m[cnt_m]   = pixel_data;
         known_m[cnt_m] = 1'b1;
         cnt_m++;
         sum_m = sum_m + pixel_data;
         if (cnt_m == PIXELS) begin
            cap_m  = 1'b0;
            done_m = 1'b1;
            frames_m++;
         end
      end
      @(posedge clock);
      #1;
      check_eq("busy", {31'd0, busy}, {31'd0, cap_m});
      check_eq("done", {31'd0, done}, {31'd0, done_m});
      check_eq("write_count", {15'd0, write_count}, 32'(cnt_m));
      if (rd_chk) begin
         check_eq("read_data", {8'd0, read_data}, {8'd0, rd_exp});
      end
`ifdef CHECKSUM_EN
      check_eq("checksum", {8'd0, checksum}, {8'd0, sum_m});
`endif
      if (done && !prev_done) begin
         done_rises++;
      end
      prev_done = done;
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      start       = 1'b0;
      pixel_valid = 1'b0;
      read_enable = 1'b0;
      #2;
      check_eq("rst_ready", {31'd0, pixel_ready}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_count", {15'd0, write_count}, 32'd0);
      check_eq("rst_read_data", {8'd0, read_data}, 32'd0);
      cap_m     = 1'b0;
      done_m    = 1'b0;
      cnt_m     = 0;
      sum_m     = 24'h000000;
      prev_done = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Random read traffic, biased towards the address being written (same-cycle
   // read-before-write) and the written region.
   task automatic rand_read();
      int r;
      r = $urandom_range(0, 19);
      read_enable = 1'b1;
      if (r < 2) begin
         read_enable  = 1'b0;
         read_address = 17'($urandom_range(0, 1700));
      end else if (r < 7) begin
         read_address = 17'(cnt_m);
      end else if (r < 17) begin
         read_address = 17'($urandom_range(0, 1700));
      end else begin
         read_address = 17'($urandom_range(0, 131071));
      end
   endtask

   initial begin
      n_total      = 0;
      n_bad        = 0;
      done_rises   = 0;
      frames_m     = 0;
      start        = 1'b0;
      pixel_valid  = 1'b0;
      pixel_data   = 24'h000000;
      read_enable  = 1'b0;
      read_address = 17'd0;
      reset_n      = 1'b1;
      #1;
      do_reset();

      // valid while idle is ignored
      pixel_valid = 1'b1;
      pixel_data  = 24'hABCDEF;
      tick();
      tick();

      // frame 1: random data with random valid gaps, abandoned after 1600 pixels
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4000 && cnt_m < 1600; i++) begin
         pixel_valid = ($urandom_range(0, 4) != 0);
         pixel_data  = 24'($urandom);
         rand_read();
         tick();
      end
      check_eq("f1_count", {15'd0, write_count}, 32'd1600);
      saved_1500 = mem_m[1500];
      do_reset();

      // frame 2: checksum wrap pattern then random data, reset after 1000 pixels
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         pixel_valid = 1'b1;
         pixel_data  = (i < 3) ? 24'h000001 : ((i == 3) ? 24'hFFFFFF : 24'($urandom));
         rand_read();
         tick();
`ifdef CHECKSUM_EN
         if (i == 3) begin
            check_eq("checksum_wrap", {8'd0, checksum}, 32'h000002);
         end
`endif
      end
      check_eq("f2_count", {15'd0, write_count}, 32'd1000);
      do_reset();
      check_eq("f2_reset_busy", {31'd0, busy}, 32'd0);
      read_enable  = 1'b1;
      read_address = 17'd1500;
      tick();
      check_eq("old_1500", {8'd0, read_data}, {8'd0, saved_1500});

      // frame 3: full frame, valid always high, data = address
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < PIXELS + 10 && cap_m; i++) begin
         pixel_valid = 1'b1;
         pixel_data  = 24'(cnt_m);
         start       = (i == 500);
         rand_read();
         tick();
      end
      start = 1'b0;
      check_eq("full_done", {31'd0, done}, 32'd1);
      check_eq("full_count", {15'd0, write_count}, 32'd90000);
      // stream keeps offering after the frame: no wrap
      pixel_valid = 1'b1;
      pixel_data  = 24'h123456;
      tick();
      pixel_valid = 1'b0;
      check_eq("no_wrap_count", {15'd0, write_count}, 32'd90000);

      read_enable  = 1'b1;
      read_address = 17'd0;
      tick();
      check_eq("rd_addr_0", {8'd0, read_data}, 32'h000000);
      read_address = 17'd299;
      tick();
      check_eq("rd_addr_299", {8'd0, read_data}, 32'h00012B);
      read_address = 17'd89999;
      tick();
      check_eq("rd_addr_89999", {8'd0, read_data}, 32'h015F8F);
      read_address = 17'd1500;
      tick();
      check_eq("rd_addr_1500_new", {8'd0, read_data}, 32'h0005DC);
      read_address = 17'd90000;
      tick();
      check_eq("rd_out_of_frame", {8'd0, read_data}, 32'h000000);
      read_enable  = 1'b0;
      read_address = 17'd299;
      tick();
      check_eq("rd_disabled", {8'd0, read_data}, 32'h000000);

      // restart from DONE: count and done clear on the same edge
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("restart_done", {31'd0, done}, 32'd0);
      check_eq("restart_count", {15'd0, write_count}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         pixel_valid = 1'b1;
         pixel_data  = 24'($urandom);
         rand_read();
         tick();
      end
      pixel_valid = 1'b0;
      tick();

      check_eq("done_rises", 32'(done_rises), 32'(frames_m));
      check_eq("frames", 32'(frames_m), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
